// File: rtl/life_controller.sv
// Game-of-Life board sequencer: tracks the entry grid in SETUP, evolves it in RUN/PAUSE,
// and parks in DONE once the board is stable or extinct.
module life_controller #(
    parameter int TICK_DIV = 25000000,
    parameter int GEN_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 step,
    input  logic                 clear,
    input  logic [7:0][7:0]      init_grid,
    input  logic [7:0][7:0]      next_grid,
    output logic [7:0][7:0]      grid,
    output logic                 freset,
    output logic [1:0]           state,
    output logic [GEN_W-1:0]     gen_count,
    output logic                 tick
);

    localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [GEN_W-1:0] GEN_MAX  = '1;

    typedef enum logic [1:0] {
        S_SETUP = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [7:0][7:0]  grid_q, grid_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic [DIV_W-1:0] div_q, div_d;

    logic atTick;
    logic isStable;
    logic isExtinct;
    logic doApply;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_SETUP;
            grid_q  <= '0;
            gen_q   <= '0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            grid_q  <= grid_d;
            gen_q   <= gen_d;
            div_q   <= div_d;
        end
    end

    always_comb begin
        atTick    = (state_q == S_RUN) && (div_q == DIV_LAST);
        isStable  = (next_grid == grid_q);
        isExtinct = (next_grid == '0);
    end

    // Priority clear > start > pause > step; an Apply latches next_grid and may end the run.
    always_comb begin
        state_d = state_q;
        grid_d  = grid_q;
        gen_d   = gen_q;
        div_d   = div_q;
        doApply = 1'b0;

        if (clear) begin
            state_d = S_SETUP;
            grid_d  = init_grid;
            gen_d   = '0;
            div_d   = '0;
        end else begin
            unique case (state_q)
                S_SETUP: begin
                    grid_d = init_grid;
                    gen_d  = '0;
                    div_d  = '0;
                    if (start) begin
                        state_d = (init_grid == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (pause && !start) begin
                        state_d = S_PAUSE;
                    end else begin
                        div_d   = atTick ? '0 : div_q + DIV_W'(1);
                        doApply = atTick;
                    end
                end
                S_PAUSE: begin
                    if (start) begin
                        state_d = S_RUN;
                    end else if (!pause && step) begin
                        doApply = 1'b1;
                    end
                end
                S_DONE: begin
                end
                default: begin
                    state_d = S_SETUP;
                end
            endcase

            if (doApply) begin
                grid_d = next_grid;
                if (!isStable && (gen_q != GEN_MAX)) begin
                    gen_d = gen_q + GEN_W'(1);
                end
                if (isStable || isExtinct) begin
                    state_d = S_DONE;
                end
            end
        end
    end

    assign grid      = grid_q;
    assign gen_count = gen_q;
    assign state     = state_q;
    assign freset    = (state_q == S_SETUP);
    assign tick      = atTick;

endmodule
